// File: rtl/fft_addr_sequencer.sv
// Address sequencer for an in-place radix-2 FFT: walks every stage x butterfly and emits
// data addresses A/B plus the twiddle ROM address, in DIT or DIF order, with a drain gap between stages.
//
// state | meaning
// IDLE  | waiting for START, outputs quiet
// RUN   | presenting butterflies, one consumed per VALID&&EN
// GAP   | pipeline drain between stages, VALID=0 for STAGE_GAP cycles
// FIN   | one-cycle DONE pulse, accepts a new START like IDLE
module fft_addr_sequencer #(
  parameter int LOG2N     = 5,
  parameter int STAGE_GAP = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic                     DIF,
  input  logic                     EN,
  output logic [LOG2N-1:0]         ADDR_A,
  output logic [LOG2N-1:0]         ADDR_B,
  output logic [LOG2N-2:0]         W_ADDR,
  output logic [$clog2(LOG2N)-1:0] STAGE,
  output logic                     VALID,
  output logic                     LAST,
  output logic                     BUSY,
  output logic                     DONE
);

  localparam int JW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int GW = (STAGE_GAP > 2) ? $clog2(STAGE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_FIN} state_t;

  state_t          r_state;
  logic [JW-1:0]   r_j;
  logic [SW-1:0]   r_s;
  logic            r_dif;
  logic [GW-1:0]   r_gap_cnt;
  logic [LOG2N-1:0] r_addr_a, r_addr_b;
  logic [JW-1:0]   r_w_addr;
  logic            r_valid, r_last, r_busy, r_done;

  logic            w_start, w_consume, w_j_last, w_s_last, w_last_nxt;
  logic [JW-1:0]   w_j_nxt;
  logic [SW-1:0]   w_s_nxt;
  logic            w_dif_nxt;
  logic [SW-1:0]   w_sh, w_wsh;
  logic [JW-1:0]   w_pos, w_grp;
  logic [LOG2N-1:0] w_span, w_addr_a, w_addr_b;
  logic [JW-1:0]   w_w_addr;

  assign w_start    = START && ((r_state == S_IDLE) || (r_state == S_FIN));
  assign w_consume  = EN && (r_state == S_RUN);
  assign w_j_last   = (r_j == '1);
  assign w_s_last   = (r_s == SW'(LOG2N - 1));
  assign w_last_nxt = (w_j_nxt == '1);

  always_comb begin
    w_j_nxt   = r_j;
    w_s_nxt   = r_s;
    w_dif_nxt = r_dif;
    if (w_start) begin
      w_j_nxt   = '0;
      w_s_nxt   = '0;
      w_dif_nxt = DIF;
    end else if (w_consume) begin
      if (!w_j_last) begin
        w_j_nxt = r_j + JW'(1);
      end else if (!w_s_last) begin
        w_j_nxt = '0;
        w_s_nxt = r_s + SW'(1);
      end
    end
  end

  // span = 2^sh; the twiddle stride uses the complementary shift
  always_comb begin
    w_sh     = w_dif_nxt ? (SW'(LOG2N - 1) - w_s_nxt) : w_s_nxt;
    w_wsh    = w_dif_nxt ? w_s_nxt : (SW'(LOG2N - 1) - w_s_nxt);
    w_span   = LOG2N'(1) << w_sh;
    w_pos    = w_j_nxt & ~({JW{1'b1}} << w_sh);
    w_grp    = w_j_nxt >> w_sh;
    w_addr_a = (({1'b0, w_grp} << w_sh) << 1) | {1'b0, w_pos};
    w_addr_b = w_addr_a | w_span;
    w_w_addr = w_pos << w_wsh;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_j       <= '0;
      r_s       <= '0;
      r_dif     <= 1'b0;
      r_gap_cnt <= '0;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_w_addr  <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_j    <= w_j_nxt;
      r_s    <= w_s_nxt;
      r_dif  <= w_dif_nxt;
      r_done <= 1'b0;
      if (w_start || w_consume) begin
        r_addr_a <= w_addr_a;
        r_addr_b <= w_addr_b;
        r_w_addr <= w_w_addr;
      end
      case (r_state)
        S_IDLE, S_FIN: begin
          if (START) begin
            r_state <= S_RUN;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_last  <= w_last_nxt;
          end else begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
          end
        end
        S_RUN: begin
          if (EN) begin
            if (!w_j_last) begin
              r_last <= w_last_nxt;
            end else if (!w_s_last) begin
              if (STAGE_GAP == 0) begin
                r_last <= w_last_nxt;
              end else begin
                r_state   <= S_GAP;
                r_valid   <= 1'b0;
                r_last    <= 1'b0;
                r_gap_cnt <= GAP_LOAD;
              end
            end else begin
              r_state <= S_FIN;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_RUN;
            r_valid <= 1'b1;
            r_last  <= w_last_nxt;
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ADDR_A = r_addr_a;
  assign ADDR_B = r_addr_b;
  assign W_ADDR = r_w_addr;
  assign STAGE  = r_s;
  assign VALID  = r_valid;
  assign LAST   = r_last;
  assign BUSY   = r_busy;
  assign DONE   = r_done;

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// Directed bench for fft_addr_sequencer: three instances (N=8 no gap, N=8 gap 2, N=32 gap 4)
// share the control inputs; each test resets all of them and checks one.
module tb_fft_addr_sequencer;

  logic CLK = 1'b0;
  logic RST, START, DIF, EN;

  logic [2:0] a3, b3, ga, gb;
  logic [1:0] w3, st3, gw, gst;
  logic       v3, l3, bz3, d3, gv, gl, gbz, gd;
  logic [4:0] a5, b5;
  logic [3:0] w5;
  logic [2:0] st5;
  logic       v5, l5, bz5, d5;

  int n_cmp = 0;
  int n_err = 0;

  // {A,B,W} packed as hex nibbles, 12 butterflies of the N=8 transform
  localparam int TBL_DIT[12] = '{'h010, 'h230, 'h450, 'h670, 'h020, 'h132,
                                 'h460, 'h572, 'h040, 'h151, 'h262, 'h373};
  localparam int TBL_DIF[12] = '{'h040, 'h151, 'h262, 'h373, 'h020, 'h132,
                                 'h460, 'h572, 'h010, 'h230, 'h450, 'h670};

  fft_addr_sequencer #(.LOG2N(3), .STAGE_GAP(0)) u3 (
    .CLK(CLK), .RST(RST), .START(START), .DIF(DIF), .EN(EN),
    .ADDR_A(a3), .ADDR_B(b3), .W_ADDR(w3), .STAGE(st3),
    .VALID(v3), .LAST(l3), .BUSY(bz3), .DONE(d3));

  fft_addr_sequencer #(.LOG2N(3), .STAGE_GAP(2)) u3g (
    .CLK(CLK), .RST(RST), .START(START), .DIF(DIF), .EN(EN),
    .ADDR_A(ga), .ADDR_B(gb), .W_ADDR(gw), .STAGE(gst),
    .VALID(gv), .LAST(gl), .BUSY(gbz), .DONE(gd));

  fft_addr_sequencer #(.LOG2N(5), .STAGE_GAP(4)) u5 (
    .CLK(CLK), .RST(RST), .START(START), .DIF(DIF), .EN(EN),
    .ADDR_A(a5), .ADDR_B(b5), .W_ADDR(w5), .STAGE(st5),
    .VALID(v5), .LAST(l5), .BUSY(bz5), .DONE(d5));

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; START = 1'b0; DIF = 1'b0; EN = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic do_start(input logic d);
    START = 1'b1;
    DIF   = d;
    tick();
    START = 1'b0;
  endtask

  function automatic int abw3(input logic [2:0] a, input logic [2:0] b, input logic [1:0] w);
    return int'(a) * 256 + int'(b) * 16 + int'(w);
  endfunction

  function automatic int abw5(input logic [4:0] a, input logic [4:0] b, input logic [3:0] w);
    return int'(a) * 1024 + int'(b) * 32 + int'(w);
  endfunction

  initial begin
    int idx, dcount, done_at, cnt, dups;
    logic prev_stall, done_seen;
    int prev_snap;
    int exp_q[$];
    logic [31:0] seen[5];

    do_reset();
    check_val("rst_u3_all_zero", {v3, l3, bz3, d3, st3, a3, b3, w3}, 32'd0);
    check_val("rst_u5_all_zero", {v5, l5, bz5, d5, st5, a5, b5, w5}, 32'd0);

    // DIT, EN=1, back-to-back stages
    do_start(1'b0);
    for (int k = 0; k < 12; k++) begin
      check_val("t1_valid", v3, 1);
      check_val("t1_busy", bz3, 1);
      check_val("t1_abw", abw3(a3, b3, w3), TBL_DIT[k]);
      check_val("t1_last", l3, (k % 4) == 3);
      check_val("t1_stage", st3, k / 4);
      check_val("t1_done_low", d3, 0);
      tick();
    end
    check_val("t1_done", {d3, bz3, v3}, 3'b100);
    tick();
    check_val("t1_done_pulse_end", {d3, bz3, v3}, 3'b000);

    // DIF ordering
    do_reset();
    do_start(1'b1);
    for (int k = 0; k < 12; k++) begin
      check_val("t2_abw", abw3(a3, b3, w3), TBL_DIF[k]);
      check_val("t2_valid", v3, 1);
      tick();
    end
    check_val("t2_done", d3, 1);

    // two idle cycles after each stage, DONE after 16 cycles
    do_reset();
    do_start(1'b0);
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      logic exp_v;
      exp_v = !((c == 4) || (c == 5) || (c == 10) || (c == 11));
      check_val("t3_valid", gv, exp_v);
      check_val("t3_busy", gbz, 1);
      check_val("t3_done_low", gd, 0);
      if (exp_v) begin
        check_val("t3_abw", abw3(ga, gb, gw), TBL_DIT[idx]);
        idx++;
      end
      tick();
    end
    check_val("t3_done", {gd, gv, gbz}, 3'b100);

    // random EN stalls: same sequence, outputs held while stalled
    do_reset();
    do_start(1'b0);
    idx = 0; prev_stall = 1'b0; prev_snap = 0; done_seen = 1'b0;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      if (d3) begin
        done_seen = 1'b1;
      end else begin
        if (prev_stall)
          check_val("t4_hold", {v3, l3, st3, a3, b3, w3}, prev_snap);
        if (v3 && idx < 12)
          check_val("t4_abw", abw3(a3, b3, w3), TBL_DIT[idx]);
        EN = 1'($urandom_range(0, 1));
        prev_stall = v3 && !EN;
        prev_snap  = int'({v3, l3, st3, a3, b3, w3});
        if (v3 && EN) idx++;
        tick();
      end
    end
    EN = 1'b1;
    check_val("t4_done_seen", done_seen, 1);
    check_val("t4_count", idx, 12);

    // START while busy is ignored; RST mid-run clears everything without DONE
    do_reset();
    do_start(1'b0);
    for (int k = 0; k < 6; k++) begin
      check_val("t5_abw", abw3(a3, b3, w3), TBL_DIT[k]);
      START = (k == 2);
      DIF   = (k == 2);
      tick();
      START = 1'b0;
      DIF   = 1'b0;
    end
    check_val("t5_at_s1j2", {st3, 12'(abw3(a3, b3, w3))}, {2'd1, 12'h460});
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_val("t5_rst_zero", {v3, l3, bz3, d3, st3, a3, b3, w3}, 32'd0);
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      if (d3 || bz3) dcount++;
      tick();
    end
    check_val("t5_no_done", dcount, 0);
    do_start(1'b0);
    check_val("t5_restart", {v3, st3, 12'(abw3(a3, b3, w3))}, {1'b1, 2'd0, 12'h010});

    // N=32 both orders against an explicit stage/group/position walk
    for (int dm = 0; dm < 2; dm++) begin
      exp_q.delete();
      for (int s = 0; s < 5; s++) begin
        int span;
        span = (dm == 1) ? (1 << (4 - s)) : (1 << s);
        for (int g = 0; g < 32; g += 2 * span)
          for (int p = 0; p < span; p++)
            exp_q.push_back((g + p) * 1024 + (g + p + span) * 32 +
                            ((dm == 1) ? (p << s) : (p << (4 - s))));
      end
      for (int s = 0; s < 5; s++) seen[s] = '0;
      do_reset();
      do_start(1'(dm));
      cnt = 0; dups = 0; done_at = -1;
      for (int c = 0; c < 400; c++) begin
        if (d5) begin
          done_at = c;
          break;
        end
        if (v5) begin
          if (cnt < 80)
            check_val(dm ? "t6_dif_abw" : "t6_dit_abw", abw5(a5, b5, w5), exp_q[cnt]);
          if (st5 < 5) begin
            if (seen[st5][a5] || seen[st5][b5]) dups++;
            seen[st5][a5] = 1'b1;
            seen[st5][b5] = 1'b1;
          end
          cnt++;
        end
        tick();
      end
      check_val("t6_butterflies", cnt, 80);
      check_val("t6_dups", dups, 0);
      check_val("t6_done_cycle", done_at, 96);
      for (int s = 0; s < 5; s++)
        check_val("t6_coverage", seen[s], 32'hFFFF_FFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
